// File: rtl/module_led_scan_mux.sv
// Registered switch-to-LED stage for NCH channels of W bits, shown either all at once or one at a time.
// Optional feature: define LED_BLINK_EN to add blink_pi and a free-running blink phase.
module module_led_scan_mux #(
    parameter int NCH       = 4,
    parameter int W         = 4,
    parameter int DIV       = 50000,
    parameter int BLINK_DIV = 25000
) (
    input  logic             clk_pi,
    input  logic             rst_pi,
    input  logic [NCH*W-1:0] s_pi,
    input  logic [NCH-1:0]   en_pi,
    input  logic             mode_pi,
`ifdef LED_BLINK_EN
    input  logic [NCH-1:0]   blink_pi,
`endif
    output logic [NCH*W-1:0] leds_po,
    output logic [NCH-1:0]   sel_po
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [NCH*W-1:0] r_s_m, r_s_s;
    logic [NCH-1:0]   r_en_m, r_en_s;
    logic             r_mode_m, r_mode_s, r_mode_d;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;

    logic [PW-1:0]    w_lowest, w_next, w_ptr_cur;
    logic             w_entry, w_tick;
    logic [NCH*W-1:0] w_leds;
    logic [NCH-1:0]   w_sel;
    logic [NCH-1:0]   w_blank;

`ifdef LED_BLINK_EN
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [NCH-1:0] r_blink_m, r_blink_s;
    logic [BCW-1:0] r_bcnt;
    logic           r_phase;

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            r_blink_m <= '0;
            r_blink_s <= '0;
            r_bcnt    <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_blink_m <= blink_pi;
            r_blink_s <= r_blink_m;
            if (r_bcnt == BCW'(BLINK_DIV - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_blank = r_blink_s & {NCH{r_phase}};
`else
    assign w_blank = '0;
`endif

    // Mode entry is seen one cycle before ptr is reloaded, so the display bypasses r_ptr then.
    assign w_entry   = r_mode_s & ~r_mode_d;
    assign w_ptr_cur = w_entry ? w_lowest : r_ptr;
    assign w_tick    = r_mode_s & ~w_entry & (r_cnt == CW'(DIV - 1));

    // Descending loops: the last match written is the nearest one.
    always_comb begin
        w_lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_en_s[i]) w_lowest = PW'(i);
        end
        w_next = r_ptr;
        for (int i = NCH - 1; i >= 1; i--) begin
            if (r_en_s[(int'(r_ptr) + i) % NCH]) w_next = PW'((int'(r_ptr) + i) % NCH);
        end
    end

    always_comb begin
        w_leds = '0;
        w_sel  = '0;
        if (!r_mode_s) begin
            for (int k = 0; k < NCH; k++) begin
                if (r_en_s[k]) w_leds[k*W +: W] = r_s_s[k*W +: W];
            end
            w_sel = r_en_s;
        end else if (r_en_s[w_ptr_cur]) begin
            w_sel[w_ptr_cur]             = 1'b1;
            w_leds[w_ptr_cur*W +: W]     = r_s_s[w_ptr_cur*W +: W];
        end
        for (int k = 0; k < NCH; k++) begin
            if (w_blank[k]) w_leds[k*W +: W] = '0;
        end
    end

    // NOTE: every register here uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            r_s_m    <= '0;
            r_s_s    <= '0;
            r_en_m   <= '0;
            r_en_s   <= '0;
            r_mode_m <= 1'b0;
            r_mode_s <= 1'b0;
            r_mode_d <= 1'b0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            leds_po  <= '0;
            sel_po   <= '0;
        end else begin
            r_s_m    <= s_pi;
            r_s_s    <= r_s_m;
            r_en_m   <= en_pi;
            r_en_s   <= r_en_m;
            r_mode_m <= mode_pi;
            r_mode_s <= r_mode_m;
            r_mode_d <= r_mode_s;
            leds_po  <= w_leds;
            sel_po   <= w_sel;
            if (!r_mode_s) begin
                r_cnt <= '0;
            end else if (w_entry) begin
                r_cnt <= '0;
                r_ptr <= w_lowest;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) r_ptr <= w_next;
            end
        end
    end

endmodule

// File: tb/tb_module_led_scan_mux.sv
// Directed bench for module_led_scan_mux (NCH=4, W=4, DIV=4, BLINK_DIV=3); blink step needs LED_BLINK_EN.
module tb_module_led_scan_mux;

    logic        clk_pi = 1'b0;
    logic        rst_pi;
    logic [15:0] s_pi;
    logic [3:0]  en_pi;
    logic        mode_pi;
`ifdef LED_BLINK_EN
    logic [3:0]  blink_pi;
`endif
    logic [15:0] leds_po;
    logic [3:0]  sel_po;

    int total = 0;
    int bad   = 0;

    module_led_scan_mux #(.NCH(4), .W(4), .DIV(4), .BLINK_DIV(3)) dut (
        .clk_pi  (clk_pi),
        .rst_pi  (rst_pi),
        .s_pi    (s_pi),
        .en_pi   (en_pi),
        .mode_pi (mode_pi),
`ifdef LED_BLINK_EN
        .blink_pi(blink_pi),
`endif
        .leds_po (leds_po),
        .sel_po  (sel_po)
    );

    always #5 clk_pi = ~clk_pi;

    task automatic step(input int n);
        repeat (n) @(negedge clk_pi);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_sel(input string tag, input logic [3:0] e, input int max);
        int n;
        n = 0;
        while (sel_po !== e && n < max) begin
            step(1);
            n++;
        end
        chk(tag, 32'(sel_po), 32'(e));
    endtask

    // Checks the current channel's value, then measures how many samples it stays selected.
    task automatic hold_check(input string tag, input logic [3:0] sel_e,
                              input logic [15:0] leds_e, input int len_e);
        int n;
        chk({tag, "_sel"}, 32'(sel_po), 32'(sel_e));
        chk({tag, "_leds"}, 32'(leds_po), 32'(leds_e));
        n = 1;
        step(1);
        while (sel_po === sel_e && n < 12) begin
            n++;
            step(1);
        end
        chk({tag, "_len"}, n, len_e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_pi  = 1'b1;
        s_pi    = '0;
        en_pi   = '0;
        mode_pi = 1'b0;
`ifdef LED_BLINK_EN
        blink_pi = '0;
`endif
        #1;
        chk("rst_leds", 32'(leds_po), 32'h0);
        chk("rst_sel", 32'(sel_po), 32'h0);
        step(2);
        rst_pi = 1'b0;

        // Parallel mode and 3-clk latency
        s_pi = 16'h1234; en_pi = 4'b1000; mode_pi = 1'b0;
        step(2);
        chk("par_latency", 32'(leds_po), 32'h0);
        step(1);
        chk("par_leds_1000", 32'(leds_po), 32'h1000);
        chk("par_sel_1000", 32'(sel_po), 32'h8);
        en_pi = 4'b1111;
        step(3);
        chk("par_leds_all", 32'(leds_po), 32'h1234);
        chk("par_sel_all", 32'(sel_po), 32'hf);
        en_pi = 4'b0000;
        step(3);
        chk("par_leds_none", 32'(leds_po), 32'h0);
        chk("par_sel_none", 32'(sel_po), 32'h0);

        // Scan through all channels
        s_pi = 16'h2321; en_pi = 4'b1111; mode_pi = 1'b1;
        step(3);
        chk("scan_entry_sel", 32'(sel_po), 32'h1);
        chk("scan_entry_leds", 32'(leds_po), 32'h0001);
        wait_sel("scan_to_ch1", 4'b0010, 8);
        hold_check("scan_ch1", 4'b0010, 16'h0020, 4);
        hold_check("scan_ch2", 4'b0100, 16'h0300, 4);
        hold_check("scan_ch3", 4'b1000, 16'h2000, 4);
        hold_check("scan_ch0", 4'b0001, 16'h0001, 4);

        // Skip disabled channels
        en_pi = 4'b0101;
        wait_sel("skip_to_ch0", 4'b0001, 20);
        hold_check("skip_ch0", 4'b0001, 16'h0001, 4);
        hold_check("skip_ch2", 4'b0100, 16'h0300, 4);
        hold_check("skip_ch0b", 4'b0001, 16'h0001, 4);

        // No channel enabled, then a late enable
        en_pi = 4'b0000;
        step(3);
        chk("none_leds", 32'(leds_po), 32'h0);
        chk("none_sel", 32'(sel_po), 32'h0);
        step(8);
        chk("none_leds_held", 32'(leds_po), 32'h0);
        chk("none_sel_held", 32'(sel_po), 32'h0);
        en_pi = 4'b0010;
        wait_sel("late_sel", 4'b0010, 12);
        chk("late_leds", 32'(leds_po), 32'h0020);

        // Asynchronous reset mid-scan
        en_pi = 4'b1111;
        step(6);
        @(posedge clk_pi);
        #2;
        rst_pi = 1'b1;
        #1;
        chk("arst_leds", 32'(leds_po), 32'h0);
        chk("arst_sel", 32'(sel_po), 32'h0);
        @(negedge clk_pi);
        rst_pi = 1'b0;
        step(3);
        chk("restart_sel", 32'(sel_po), 32'h1);
        chk("restart_leds", 32'(leds_po), 32'h0001);
        wait_sel("restart_to_ch1", 4'b0010, 8);
        hold_check("restart_ch1", 4'b0010, 16'h0020, 4);

`ifdef LED_BLINK_EN
        // Blink in parallel mode: channel 0 blanked every other 3-clk phase
        mode_pi = 1'b0; s_pi = 16'h1234; en_pi = 4'b1111; blink_pi = 4'b0001;
        step(4);
        n = 0;
        while (leds_po !== 16'h1230 && n < 10) begin
            step(1);
            n++;
        end
        chk("blink_off", 32'(leds_po), 32'h1230);
        chk("blink_sel", 32'(sel_po), 32'hf);
        n = 0;
        while (leds_po === 16'h1230 && n < 10) begin
            step(1);
            n++;
        end
        chk("blink_off_len", n, 3);
        chk("blink_on", 32'(leds_po), 32'h1234);
        n = 0;
        while (leds_po === 16'h1234 && n < 10) begin
            step(1);
            n++;
        end
        chk("blink_on_len", n, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
